sseg_serial_drv: RTL and testbench

SSEG_SERIAL_DRV -- requirements
Module: sseg_serial_drv

---
 rtl/sseg_pkg.sv | 19 +
 rtl/sseg_hex_decode.sv | 15 +
 rtl/sseg_serial_drv.sv | 132 +++++++++++++
 tb/tb_sseg_serial_drv.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and constants for the serial 7-segment driver.
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH
  } state_e;

  localparam logic [7:0] BLANK_SEG = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}, dp off
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/sseg_hex_decode.sv
// Nibble to active-low segment byte, with optional decimal point.
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = HEX_SEG[nibble_i];
    if (dp_i) seg_o[7] = 1'b0;
  end

endmodule

// File: rtl/sseg_serial_drv.sv
// Serialises one byte per digit into an external 7-segment shift-register
// chain, most significant digit and bit first, then pulses the latch enable.
module sseg_serial_drv
  import sseg_pkg::*;
#(
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned CLK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic                  mode,
  input  logic                  flash,
  input  logic [4*DIGITS-1:0]   Hexs,
  input  logic [8*DIGITS-1:0]   Raw,
  input  logic [DIGITS-1:0]     point,
  input  logic [DIGITS-1:0]     LES,
  output logic                  seg_clk,
  output logic                  seg_sout,
  output logic                  SEG_PEN,
  output logic                  seg_clrn,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned NBITS = 8 * DIGITS;
  localparam int unsigned BCW   = $clog2(NBITS + 1);
  localparam int unsigned DVW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DVW-1:0] DIV_LAST  = DVW'(CLK_DIV - 1);
  localparam logic [BCW-1:0] BITS_INIT = BCW'(NBITS);

  state_e             state_q;
  logic               start_q;
  logic               start_prev_q;
  logic [NBITS-1:0]   sreg_q;
  logic [NBITS-1:0]   frame_d;
  logic [BCW-1:0]     bitcnt_q;
  logic [DVW-1:0]     div_q;
  logic               seg_clk_q;
  logic               seg_pen_q;
  logic               seg_clrn_q;
  logic               busy_q;
  logic               done_q;
  logic               start_edge;

  assign start_edge = start_q & ~start_prev_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [7:0] hex_seg;

    sseg_hex_decode u_dec (
      .nibble_i (Hexs[4*i +: 4]),
      .dp_i     (point[i]),
      .seg_o    (hex_seg)
    );

    assign frame_d[8*i +: 8] = (flash && LES[i]) ? BLANK_SEG :
                               (mode ? Raw[8*i +: 8] : hex_seg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      sreg_q       <= '0;
      bitcnt_q     <= '0;
      div_q        <= '0;
      seg_clk_q    <= 1'b0;
      seg_pen_q    <= 1'b1;
      seg_clrn_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      start_q      <= Start;
      start_prev_q <= start_q;
      seg_clrn_q   <= 1'b1;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_q   <= LOAD;
            busy_q    <= 1'b1;
            seg_pen_q <= 1'b0;
          end
        end
        LOAD: begin
          sreg_q    <= frame_d;
          bitcnt_q  <= BITS_INIT;
          div_q     <= '0;
          seg_clk_q <= 1'b0;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (!seg_clk_q) begin
              seg_clk_q <= 1'b1;
            end else begin
              // End of high phase: advance to the next bit or finish the frame
              seg_clk_q <= 1'b0;
              bitcnt_q  <= bitcnt_q - 1'b1;
              if (bitcnt_q == BCW'(1)) begin
                sreg_q    <= '0;
                seg_pen_q <= 1'b1;
                state_q   <= LATCH;
              end else begin
                sreg_q <= {sreg_q[NBITS-2:0], 1'b0};
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        LATCH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign seg_clk  = seg_clk_q;
  assign seg_sout = sreg_q[NBITS-1];
  assign SEG_PEN  = seg_pen_q;
  assign seg_clrn = seg_clrn_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sseg_serial_drv.sv
// Scoreboard bench: expected bytes queued at frame start, compared against
// bytes reassembled from seg_clk rising edges.
module tb_sseg_serial_drv;

  logic clk = 1'b0;
  logic rst;

  logic        Start8, mode8, flash8;
  logic [31:0] hexs8;
  logic [63:0] raw8;
  logic [7:0]  point8, les8;
  logic        sclk8, sout8, pen8, clrn8, busy8, done8;

  logic        Start4, mode4, flash4;
  logic [15:0] hexs4;
  logic [31:0] raw4;
  logic [3:0]  point4, les4;
  logic        sclk4, sout4, pen4, clrn4, busy4, done4;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp8[$];
  logic [7:0] obs8[$];
  logic [7:0] exp4[$];

  logic [7:0] acc8;
  int         nb8;
  int         rise8 = 0;
  logic       prev8;

  always #5 clk = ~clk;

  sseg_serial_drv #(.DIGITS(8), .CLK_DIV(1)) dut8 (
    .clk(clk), .rst(rst), .Start(Start8), .mode(mode8), .flash(flash8),
    .Hexs(hexs8), .Raw(raw8), .point(point8), .LES(les8),
    .seg_clk(sclk8), .seg_sout(sout8), .SEG_PEN(pen8), .seg_clrn(clrn8),
    .busy(busy8), .done(done8)
  );

  sseg_serial_drv #(.DIGITS(4), .CLK_DIV(3)) dut4 (
    .clk(clk), .rst(rst), .Start(Start4), .mode(mode4), .flash(flash4),
    .Hexs(hexs4), .Raw(raw4), .point(point4), .LES(les4),
    .seg_clk(sclk4), .seg_sout(sout4), .SEG_PEN(pen4), .seg_clrn(clrn4),
    .busy(busy4), .done(done4)
  );

  always @(negedge clk) begin
    if (rst) begin
      acc8  = '0;
      nb8   = 0;
      prev8 = 1'b0;
    end else begin
      if (sclk8 && !prev8) begin
        acc8 = {acc8[6:0], sout8};
        nb8++;
        rise8++;
        if (nb8 == 8) begin
          obs8.push_back(acc8);
          nb8 = 0;
        end
      end
      prev8 = sclk8;
    end
  end

  task automatic push8(input logic [63:0] v);
    for (int i = 7; i >= 0; i--) exp8.push_back(v[8*i +: 8]);
  endtask

  task automatic start8();
    @(negedge clk);
    Start8 = 1'b1;
    @(posedge clk);
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 5) Start8 = 1'b0;
    end while (!done8 && lat < 1000);
  endtask

  task automatic test_reset();
    logic [5:0] o8, o4;
    #1;
    repeat (2) begin
      o8 = {sclk8, sout8, pen8, clrn8, busy8, done8};
      o4 = {sclk4, sout4, pen4, clrn4, busy4, done4};
      n_vec += 2;
      if (o8 !== 6'b001000) begin n_err++; $display("FAIL reset_out8: got %b want 001000", o8); end
      if (o4 !== 6'b001000) begin n_err++; $display("FAIL reset_out4: got %b want 001000", o4); end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_vec += 2;
    if (clrn8 !== 1'b1) begin n_err++; $display("FAIL clrn_release8: got %b want 1", clrn8); end
    if (clrn4 !== 1'b1) begin n_err++; $display("FAIL clrn_release4: got %b want 1", clrn4); end
  endtask

  task automatic test_hex();
    int lat;
    logic [7:0] e, o;
    mode8 = 1'b0; hexs8 = 32'h12345678; point8 = '0; flash8 = 1'b0; les8 = '0;
    push8(64'hF9A4B0999282F880);
    start8();
    wait_done8(lat);
    n_vec++;
    if (lat !== 131) begin n_err++; $display("FAIL hex_latency: got %0d want 131", lat); end
    while (exp8.size() > 0) begin
      e = exp8.pop_front();
      o = (obs8.size() > 0) ? obs8.pop_front() : 8'bx;
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL hex_byte: got %h want %h", o, e); end
    end
  endtask

  task automatic test_point_flash();
    int lat;
    logic [7:0] e, o;
    mode8 = 1'b0; hexs8 = 32'h557EF7E0; point8 = 8'h80; flash8 = 1'b1; les8 = 8'h01;
    push8(64'h1292F8868EF886FF);
    start8();
    wait_done8(lat);
    n_vec++;
    if (done8 !== 1'b1) begin n_err++; $display("FAIL pf_done: got %b want 1 (timeout)", done8); end
    while (exp8.size() > 0) begin
      e = exp8.pop_front();
      o = (obs8.size() > 0) ? obs8.pop_front() : 8'bx;
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL pf_byte: got %h want %h", o, e); end
    end
  endtask

  task automatic test_raw();
    int lat;
    logic [7:0] e, o;
    mode8 = 1'b1; raw8 = 64'h0123456789ABCDEF; point8 = 8'hFF; les8 = 8'hFF; flash8 = 1'b0;
    push8(64'h0123456789ABCDEF);
    start8();
    repeat (10) @(posedge clk);
    // inputs changed in flight must not disturb the captured frame
    raw8 = 64'hFEDCBA9876543210; flash8 = 1'b1;
    wait_done8(lat);
    while (exp8.size() > 0) begin
      e = exp8.pop_front();
      o = (obs8.size() > 0) ? obs8.pop_front() : 8'bx;
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL raw_byte: got %h want %h", o, e); end
    end
    raw8 = 64'h0123456789ABCDEF; flash8 = 1'b1;
    push8(64'hFFFFFFFFFFFFFFFF);
    start8();
    repeat (10) @(posedge clk);
    flash8 = 1'b0;
    wait_done8(lat);
    while (exp8.size() > 0) begin
      e = exp8.pop_front();
      o = (obs8.size() > 0) ? obs8.pop_front() : 8'bx;
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL raw_blank_byte: got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, lat2;
    logic [7:0] e, o;
    mode8 = 1'b0; hexs8 = 32'hCAFE0BD1; point8 = '0; flash8 = 1'b0; les8 = '0;
    push8(64'hC6888E86C083A1F9);
    start8();
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 5) Start8 = 1'b0;
      if (lat == 130) begin
        Start8 = 1'b1;
        hexs8  = 32'h12345678;
      end
    end while (!done8 && lat < 1000);
    push8(64'hF9A4B0999282F880);
    n_vec++;
    if (lat !== 131) begin n_err++; $display("FAIL b2b_lat1: got %0d want 131", lat); end
    @(posedge clk);
    #1;
    n_vec++;
    if ({busy8, done8} !== 2'b10) begin n_err++; $display("FAIL b2b_reload: busy/done got %b want 10", {busy8, done8}); end
    lat2 = 1;
    do begin
      @(posedge clk);
      #1;
      lat2++;
      if (lat2 == 10) Start8 = 1'b0;
    end while (!done8 && lat2 < 1000);
    n_vec++;
    if (lat2 !== 131) begin n_err++; $display("FAIL b2b_lat2: got %0d want 131", lat2); end
    while (exp8.size() > 0) begin
      e = exp8.pop_front();
      o = (obs8.size() > 0) ? obs8.pop_front() : 8'bx;
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL b2b_byte: got %h want %h", o, e); end
    end
  endtask

  task automatic test_clk_div();
    int lat, ndone, nbusy, nrise, bad_hi, hirun;
    logic prev, fired;
    logic [7:0] acc, e;
    int nb;
    mode4 = 1'b0; hexs4 = 16'h9A0F; point4 = 4'b0010; flash4 = 1'b0; les4 = '0; raw4 = '0;
    exp4.push_back(8'h90); exp4.push_back(8'h88); exp4.push_back(8'h40); exp4.push_back(8'h8E);
    lat = -1; ndone = 0; nbusy = 0; nrise = 0; bad_hi = 0; hirun = 0;
    prev = 1'b0; nb = 0; acc = '0; fired = 1'b0;
    @(negedge clk);
    Start4 = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk);
      #1;
      if (busy4) nbusy++;
      if (done4) begin
        ndone++;
        if (!fired) lat = cyc;
        fired = 1'b1;
      end
      if (sclk4) begin
        if (!prev) begin
          nrise++;
          acc = {acc[6:0], sout4};
          nb++;
          if (nb == 8) begin
            nb = 0;
            e = (exp4.size() > 0) ? exp4.pop_front() : 8'bx;
            n_vec++;
            if (acc !== e) begin n_err++; $display("FAIL div_byte: got %h want %h", acc, e); end
          end
        end
        hirun++;
      end else if (prev) begin
        if (hirun != 3) bad_hi++;
        hirun = 0;
      end
      prev = sclk4;
      if (cyc == 60 || cyc == 120 || cyc == 180) Start4 = ~Start4;
    end
    n_vec += 6;
    if (ndone !== 1) begin n_err++; $display("FAIL div_frames: got %0d want 1", ndone); end
    if (lat !== 195) begin n_err++; $display("FAIL div_latency: got %0d want 195", lat); end
    if (nbusy !== 194) begin n_err++; $display("FAIL div_busy_len: got %0d want 194", nbusy); end
    if (nrise !== 32) begin n_err++; $display("FAIL div_rises: got %0d want 32", nrise); end
    if (bad_hi !== 0) begin n_err++; $display("FAIL div_high_phase: got %0d bad runs want 0", bad_hi); end
    if (exp4.size() !== 0) begin n_err++; $display("FAIL div_bytes_left: got %0d want 0", exp4.size()); end
  endtask

  task automatic test_reset_mid();
    int lat, base, k;
    logic [7:0] e, o;
    logic [5:0] o8;
    mode8 = 1'b0; hexs8 = 32'h87654321; point8 = '0; flash8 = 1'b0; les8 = '0;
    base = rise8;
    start8();
    Start8 = 1'b0;
    k = 0;
    while (rise8 - base < 20 && k < 1000) begin
      @(negedge clk);
      #1;
      k++;
    end
    #2;
    rst = 1'b1;
    #1;
    o8 = {sclk8, sout8, pen8, clrn8, busy8, done8};
    n_vec++;
    if (o8 !== 6'b001000) begin n_err++; $display("FAIL midrst_out: got %b want 001000", o8); end
    obs8.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if ({clrn8, busy8} !== 2'b10) begin n_err++; $display("FAIL midrst_release: clrn/busy got %b want 10", {clrn8, busy8}); end
    k = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done8 || busy8) k++;
    end
    n_vec++;
    if (k !== 0 || obs8.size() !== 0) begin
      n_err++; $display("FAIL midrst_resume: got %0d active cycles %0d bytes want 0 0", k, obs8.size());
    end
    push8(64'h80F8829299B0A4F9);
    start8();
    wait_done8(lat);
    n_vec++;
    if (lat !== 131) begin n_err++; $display("FAIL midrst_latency: got %0d want 131", lat); end
    while (exp8.size() > 0) begin
      e = exp8.pop_front();
      o = (obs8.size() > 0) ? obs8.pop_front() : 8'bx;
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL midrst_byte: got %h want %h", o, e); end
    end
  endtask

  initial begin
    rst = 1'b1;
    Start8 = 1'b0; mode8 = 1'b0; flash8 = 1'b0; hexs8 = '0; raw8 = '0; point8 = '0; les8 = '0;
    Start4 = 1'b0; mode4 = 1'b0; flash4 = 1'b0; hexs4 = '0; raw4 = '0; point4 = '0; les4 = '0;
    test_reset();
    repeat (3) @(posedge clk);
    test_hex();
    test_point_flash();
    test_raw();
    test_back_to_back();
    repeat (5) @(posedge clk);
    test_clk_div();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
